// File: rtl/calc_key_sequencer_if.sv
// Handshake bundle between the scan-code receiver, the key sequencer and the
// operand/ALU/display datapath.
interface calc_key_sequencer_if #(
   parameter int WIDTH = 6
);
   logic             code_valid;
   logic [7:0]       code;
   logic             result_valid;
   logic             ld_op1;
   logic             ld_op2;
   logic             ld_opsel;
   logic             op_sel;
   logic [WIDTH-1:0] op_data;
   logic             exec;
   logic [WIDTH-1:0] entry;
   logic [2:0]       phase;
   logic             err;

   modport master (
      input  code_valid, code, result_valid,
      output ld_op1, ld_op2, ld_opsel, op_sel, op_data, exec, entry, phase, err
   );

   modport slave (
      output code_valid, code, result_valid,
      input  ld_op1, ld_op2, ld_opsel, op_sel, op_data, exec, entry, phase, err
   );
endinterface

// File: rtl/calc_key_sequencer.sv
// Turns PS/2 set-2 break codes into operand load / operator select / execute
// strobes for the calculator datapath, with decimal entry and idle timeout.
module calc_key_sequencer #(
   parameter int WIDTH   = 6,
   parameter int TIMEOUT = 1000000
) (
   input  logic                 clk,
   input  logic                 reset,
   calc_key_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      ST_OP1  = 3'd0,
      ST_OPER = 3'd1,
      ST_OP2  = 3'd2,
      ST_WAIT = 3'd3,
      ST_SHOW = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      K_DIGIT, K_PLUS, K_MINUS, K_ENTER, K_ESC, K_OTHER
   } key_t;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [WIDTH+3:0] ACC_MAX = {4'b0000, {WIDTH{1'b1}}};

   state_t           state_reg;
   logic             f0_reg;
   logic [WIDTH-1:0] acc_reg;
   logic [1:0]       dcnt_reg;
   logic             err_reg;
   logic             pend_reg;
   logic [TW-1:0]    tcnt_reg;
   logic             ld_op1_reg;
   logic             ld_op2_reg;
   logic             ld_opsel_reg;
   logic             op_sel_reg;
   logic             exec_reg;
   logic [WIDTH-1:0] op_data_reg;

   key_t       key_kind;
   logic [3:0] key_digit;

   always_comb begin
      key_kind  = K_DIGIT;
      key_digit = 4'd0;
      case (bus.code)
         8'h45:   key_digit = 4'd0;
         8'h16:   key_digit = 4'd1;
         8'h1E:   key_digit = 4'd2;
         8'h26:   key_digit = 4'd3;
         8'h25:   key_digit = 4'd4;
         8'h2E:   key_digit = 4'd5;
         8'h36:   key_digit = 4'd6;
         8'h3D:   key_digit = 4'd7;
         8'h3E:   key_digit = 4'd8;
         8'h46:   key_digit = 4'd9;
         8'h79:   key_kind  = K_PLUS;
         8'h7B:   key_kind  = K_MINUS;
         8'h5A:   key_kind  = K_ENTER;
         8'h76:   key_kind  = K_ESC;
         default: key_kind  = K_OTHER;
      endcase
   end

   // A key event is the first non-prefix byte after F0; E0 is transparent.
   logic key_event;
   assign key_event = bus.code_valid && f0_reg && (bus.code != 8'hE0) && (bus.code != 8'hF0);

   logic [WIDTH+3:0] acc_wide;
   logic [WIDTH+3:0] acc_sum;
   logic             digit_fits;
   logic [WIDTH-1:0] acc_dig;
   logic [1:0]       dcnt_dig;
   assign acc_wide   = {4'b0000, acc_reg};
   assign acc_sum    = (acc_wide << 3) + (acc_wide << 1) + {{WIDTH{1'b0}}, key_digit};
   assign digit_fits = (acc_sum <= ACC_MAX);
   assign acc_dig    = digit_fits ? acc_sum[WIDTH-1:0] : acc_reg;
   assign dcnt_dig   = (digit_fits && dcnt_reg != 2'd3) ? dcnt_reg + 2'd1 : dcnt_reg;

   logic timer_run;
   logic timer_expire;
   assign timer_run    = ((state_reg == ST_OP1) && (dcnt_reg != 2'd0)) ||
                         ((state_reg == ST_OP2) && !pend_reg);
   assign timer_expire = timer_run && !bus.code_valid && (tcnt_reg == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_OP1;
         f0_reg       <= 1'b0;
         acc_reg      <= '0;
         dcnt_reg     <= 2'd0;
         err_reg      <= 1'b0;
         pend_reg     <= 1'b0;
         tcnt_reg     <= '0;
         ld_op1_reg   <= 1'b0;
         ld_op2_reg   <= 1'b0;
         ld_opsel_reg <= 1'b0;
         op_sel_reg   <= 1'b0;
         exec_reg     <= 1'b0;
         op_data_reg  <= '0;
      end else begin
         ld_op1_reg   <= 1'b0;
         ld_op2_reg   <= 1'b0;
         ld_opsel_reg <= 1'b0;
         exec_reg     <= 1'b0;

         if (state_reg == ST_WAIT || pend_reg)
            f0_reg <= 1'b0;
         else if (bus.code_valid) begin
            if (bus.code == 8'hF0)
               f0_reg <= 1'b1;
            else if (bus.code != 8'hE0)
               f0_reg <= 1'b0;
         end

         if (bus.code_valid || !timer_run || timer_expire)
            tcnt_reg <= '0;
         else
            tcnt_reg <= tcnt_reg + 1'b1;

         case (state_reg)
            ST_OP1: begin
               if (timer_expire) begin
                  acc_reg  <= '0;
                  dcnt_reg <= 2'd0;
                  err_reg  <= 1'b1;
               end else if (key_event) begin
                  case (key_kind)
                     K_DIGIT: begin
                        acc_reg  <= acc_dig;
                        dcnt_reg <= dcnt_dig;
                        err_reg  <= !digit_fits;
                     end
                     K_PLUS, K_MINUS: begin
                        if (dcnt_reg != 2'd0) begin
                           ld_op1_reg   <= 1'b1;
                           ld_opsel_reg <= 1'b1;
                           op_sel_reg   <= (key_kind == K_PLUS);
                           op_data_reg  <= acc_reg;
                           acc_reg      <= '0;
                           dcnt_reg     <= 2'd0;
                           err_reg      <= 1'b0;
                           state_reg    <= ST_OP2;
                        end else
                           err_reg <= 1'b1;
                     end
                     K_ESC: begin
                        acc_reg  <= '0;
                        dcnt_reg <= 2'd0;
                        err_reg  <= 1'b0;
                     end
                     default: err_reg <= 1'b1;
                  endcase
               end
            end
            ST_OP2: begin
               // Second half of Enter: exec trails ld_op2 by one cycle.
               if (pend_reg) begin
                  exec_reg  <= 1'b1;
                  pend_reg  <= 1'b0;
                  state_reg <= ST_WAIT;
               end else if (timer_expire) begin
                  acc_reg   <= '0;
                  dcnt_reg  <= 2'd0;
                  err_reg   <= 1'b1;
                  state_reg <= ST_OP1;
               end else if (key_event) begin
                  case (key_kind)
                     K_DIGIT: begin
                        acc_reg  <= acc_dig;
                        dcnt_reg <= dcnt_dig;
                        err_reg  <= !digit_fits;
                     end
                     K_ENTER: begin
                        if (dcnt_reg != 2'd0) begin
                           ld_op2_reg  <= 1'b1;
                           op_data_reg <= acc_reg;
                           pend_reg    <= 1'b1;
                           err_reg     <= 1'b0;
                        end else
                           err_reg <= 1'b1;
                     end
                     K_ESC: begin
                        acc_reg   <= '0;
                        dcnt_reg  <= 2'd0;
                        err_reg   <= 1'b0;
                        state_reg <= ST_OP1;
                     end
                     default: err_reg <= 1'b1;
                  endcase
               end
            end
            ST_WAIT: begin
               if (bus.result_valid)
                  state_reg <= ST_SHOW;
            end
            ST_SHOW: begin
               if (key_event) begin
                  if (key_kind == K_DIGIT) begin
                     acc_reg   <= WIDTH'(key_digit);
                     dcnt_reg  <= 2'd1;
                     err_reg   <= 1'b0;
                     state_reg <= ST_OP1;
                  end else if (key_kind == K_ESC) begin
                     acc_reg   <= '0;
                     dcnt_reg  <= 2'd0;
                     err_reg   <= 1'b0;
                     state_reg <= ST_OP1;
                  end
               end
            end
            default: state_reg <= ST_OP1;
         endcase
      end
   end

   assign bus.ld_op1   = ld_op1_reg;
   assign bus.ld_op2   = ld_op2_reg;
   assign bus.ld_opsel = ld_opsel_reg;
   assign bus.op_sel   = op_sel_reg;
   assign bus.op_data  = op_data_reg;
   assign bus.exec     = exec_reg;
   assign bus.entry    = acc_reg;
   assign bus.phase    = state_reg;
   assign bus.err      = err_reg;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed and randomized scan-code traffic for calc_key_sequencer, checked every
// cycle against a behavioural model of the calculator key protocol.
module tb_calc_key_sequencer;
   localparam int WIDTH   = 6;
   localparam int TIMEOUT = 16;
   localparam int MAXV    = (1 << WIDTH) - 1;

   logic clk = 1'b0;
   logic reset;

   calc_key_sequencer_if #(.WIDTH(WIDTH)) bus ();

   calc_key_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                    8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   function automatic int digit_of(input logic [7:0] k);
      for (int i = 0; i < 10; i++)
         if (digit_codes[i] == k) return i;
      return -1;
   endfunction

   // Behavioural model: mode 0=entering operand 1, 2=operand 2, 3=waiting, 4=showing.
   int m_state, m_acc, m_nd, m_idle, m_opdata;
   bit m_err, m_f0, m_pend, m_opsel;
   bit m_ld1, m_ld2, m_lds, m_exec;

   function automatic void clear_entry(input bit set_err);
      m_acc = 0;
      m_nd  = 0;
      m_err = set_err;
   endfunction

   function automatic void add_digit(input int d);
      int nxt;
      nxt = m_acc * 10 + d;
      if (nxt > MAXV)
         m_err = 1;
      else begin
         m_acc = nxt;
         m_nd  = (m_nd < 3) ? m_nd + 1 : 3;
         m_err = 0;
      end
   endfunction

   function automatic void key_event(input logic [7:0] k);
      int d;
      d = digit_of(k);
      if (k == 8'h76) begin
         clear_entry(0);
         m_state = 0;
         return;
      end
      if (m_state == 0) begin
         if (d >= 0) add_digit(d);
         else if ((k == 8'h79 || k == 8'h7B) && m_nd > 0) begin
            m_ld1 = 1; m_lds = 1;
            m_opsel = (k == 8'h79);
            m_opdata = m_acc;
            clear_entry(0);
            m_state = 2;
         end else m_err = 1;
      end else if (m_state == 2) begin
         if (d >= 0) add_digit(d);
         else if (k == 8'h5A && m_nd > 0) begin
            m_ld2 = 1;
            m_opdata = m_acc;
            m_pend = 1;
            m_err = 0;
         end else m_err = 1;
      end else if (m_state == 4 && d >= 0) begin
         m_acc = d; m_nd = 1; m_err = 0; m_state = 0;
      end
   endfunction

   function automatic void model_step(input bit rst, input bit cv, input logic [7:0] cd, input bit rv);
      bit running, timed_out;
      m_ld1 = 0; m_ld2 = 0; m_lds = 0; m_exec = 0;
      if (rst) begin
         m_state = 0; clear_entry(0); m_f0 = 0; m_idle = 0; m_pend = 0;
         m_opsel = 0; m_opdata = 0;
         return;
      end
      running   = (m_state == 0 && m_nd > 0) || (m_state == 2 && !m_pend);
      timed_out = 0;
      if (cv || !running) m_idle = 0;
      else begin
         m_idle++;
         if (m_idle == TIMEOUT) begin timed_out = 1; m_idle = 0; end
      end
      if (m_pend) begin
         m_exec = 1; m_pend = 0; m_state = 3; m_f0 = 0;
         return;
      end
      if (m_state == 3) begin
         m_f0 = 0;
         if (rv) m_state = 4;
         return;
      end
      if (timed_out) begin
         clear_entry(1);
         m_state = 0;
         return;
      end
      if (!cv || cd == 8'hE0) return;
      if (cd == 8'hF0) begin m_f0 = 1; return; end
      if (!m_f0) return;
      m_f0 = 0;
      key_event(cd);
   endfunction

   // Per-cycle compare against the model, just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         model_step(reset, bus.code_valid, bus.code, bus.result_valid);
         #1;
         check("ld_op1",   bus.ld_op1,   m_ld1);
         check("ld_op2",   bus.ld_op2,   m_ld2);
         check("ld_opsel", bus.ld_opsel, m_lds);
         check("exec",     bus.exec,     m_exec);
         check("phase",    bus.phase,    m_state);
         check("entry",    bus.entry,    m_acc);
         check("err",      bus.err,      m_err);
         if (m_ld1 || m_ld2) check("op_data", bus.op_data, m_opdata);
         if (m_lds)          check("op_sel",  bus.op_sel,  m_opsel);
      end
   end

   // Driver tasks start and end on a falling edge.
   task automatic send_byte(input logic [7:0] b);
      bus.code_valid = 1'b1;
      bus.code       = b;
      @(negedge clk);
      bus.code_valid = 1'b0;
   endtask

   task automatic key(input logic [7:0] k);
      send_byte(8'hF0);
      send_byte(k);
   endtask

   task automatic pulse_result();
      bus.result_valid = 1'b1;
      @(negedge clk);
      bus.result_valid = 1'b0;
   endtask

   function automatic logic [7:0] rand_code();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 40) return 8'hF0;
      if (r < 45) return 8'hE0;
      if (r < 75) return digit_codes[$urandom_range(0, 9)];
      if (r < 82) return 8'h79;
      if (r < 88) return 8'h7B;
      if (r < 94) return 8'h5A;
      if (r < 97) return 8'h76;
      return 8'h1C;
   endfunction

   initial begin
      int blen, gap;
      reset = 1'b1;
      bus.code_valid = 1'b0;
      bus.code = 8'h00;
      bus.result_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_phase", bus.phase, 0);
      check("rst_entry", bus.entry, 0);
      check("rst_err", bus.err, 0);
      check("rst_op_data", bus.op_data, 0);
      check("rst_strobes", {bus.ld_op1, bus.ld_op2, bus.ld_opsel, bus.exec, bus.op_sel}, 0);

      // 1 + 3, Enter, result
      key(8'h16);
      key(8'h79);
      check("t1_ld_op1", bus.ld_op1, 1);
      check("t1_ld_opsel", bus.ld_opsel, 1);
      check("t1_op1_data", bus.op_data, 1);
      check("t1_op_sel", bus.op_sel, 1);
      key(8'h26);
      key(8'h5A);
      check("t1_ld_op2", bus.ld_op2, 1);
      check("t1_op2_data", bus.op_data, 3);
      check("t1_no_early_exec", bus.exec, 0);
      @(negedge clk);
      check("t1_exec", bus.exec, 1);
      check("t1_wait", bus.phase, 3);
      pulse_result();
      check("t1_show", bus.phase, 4);
      key(8'h76);

      // Operator with no digits, then Esc
      key(8'h79);
      check("t5_err", bus.err, 1);
      check("t5_no_ld_op1", bus.ld_op1, 0);
      key(8'h76);
      check("t5_esc_err", bus.err, 0);
      check("t5_esc_phase", bus.phase, 0);

      // Overflow at 2^WIDTH-1
      key(8'h36);
      key(8'h26);
      check("t2_entry63", bus.entry, 63);
      key(8'h36);
      check("t2_ovf_err", bus.err, 1);
      check("t2_ovf_entry", bus.entry, 63);
      key(8'h76);

      // Make code ignored, E0 F0 5A acts as Enter
      key(8'h16);
      key(8'h7B);
      check("t3_op_sel_sub", bus.op_sel, 0);
      key(8'h2E);
      send_byte(8'h16);
      check("t3_make_ignored", bus.entry, 5);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h5A);
      check("t3_ld_op2", bus.ld_op2, 1);
      check("t3_op2_data", bus.op_data, 5);
      @(negedge clk);
      pulse_result();
      key(8'h76);

      // Timeout, then a byte landing in the expiry cycle
      key(8'h25);
      repeat (TIMEOUT - 1) @(negedge clk);
      check("t4_pre_timeout", bus.entry, 4);
      @(negedge clk);
      check("t4_to_phase", bus.phase, 0);
      check("t4_to_entry", bus.entry, 0);
      check("t4_to_err", bus.err, 1);
      key(8'h25);
      repeat (TIMEOUT - 1) @(negedge clk);
      send_byte(8'hF0);
      check("t4_saved_entry", bus.entry, 4);
      check("t4_saved_err", bus.err, 0);
      send_byte(8'h16);
      check("t4_entry41", bus.entry, 41);
      key(8'h76);

      // Reset in the cycle after Enter suppresses exec
      key(8'h16);
      key(8'h79);
      key(8'h26);
      key(8'h5A);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_no_exec", bus.exec, 0);
      check("t6_phase", bus.phase, 0);
      check("t6_outputs", {bus.ld_op1, bus.ld_op2, bus.ld_opsel, bus.op_sel, bus.err}, 0);
      check("t6_entry", bus.entry, 0);
      check("t6_op_data", bus.op_data, 0);
      @(negedge clk);
      check("t6_no_exec_later", bus.exec, 0);

      // Randomized bursts separated by idle gaps around the timeout length
      for (int it = 0; it < 300; it++) begin
         blen = int'($urandom_range(1, 20));
         for (int c = 0; c < blen; c++) begin
            bus.code_valid   = ($urandom_range(0, 99) < 70);
            bus.code         = rand_code();
            bus.result_valid = ($urandom_range(0, 5) == 0);
            reset            = ($urandom_range(0, 299) == 0);
            @(negedge clk);
         end
         bus.code_valid   = 1'b0;
         bus.result_valid = 1'b0;
         reset            = 1'b0;
         gap = int'($urandom_range(0, TIMEOUT + 4));
         repeat (gap) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
